// File: rtl/latch_bank_wr_ctrl_if.sv
// ----------------------------------------------------------------------------
// latch_bank_wr_ctrl_if
//   Command and latch-pin bundle between a write requester and the latch bank
//   write controller.
//
//   Handshake: a command is transferred on a rising CLK edge where REQ (or
//   INIT) and RDY are both high. RDY is a registered "idle" flag. The
//   requester may hold REQ high across cycles. ADDR and WDATA are only looked
//   at in the accepting cycle. INIT outranks REQ; a REQ that loses to INIT is
//   simply still pending afterwards.
//
//   Signals:
//     REQ   write command valid            (master -> slave)
//     ADDR  target entry                   (master -> slave)
//     WDATA write data                     (master -> slave)
//     INIT  bank preset request            (master -> slave)
//     RDY   controller idle                (slave -> master)
//     E     per-entry latch enable         (slave -> latch array)
//     D     shared latch data bus          (slave -> latch array)
//     SETN  per-entry active-low preset    (slave -> latch array)
//     ERR   out-of-range address pulse     (slave -> master)
// ----------------------------------------------------------------------------
interface latch_bank_wr_ctrl_if #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              REQ;
    logic [ADDR_W-1:0] ADDR;
    logic [WIDTH-1:0]  WDATA;
    logic              INIT;
    logic              RDY;
    logic [DEPTH-1:0]  E;
    logic [WIDTH-1:0]  D;
    logic [DEPTH-1:0]  SETN;
    logic              ERR;

    modport master (
        output REQ, ADDR, WDATA, INIT,
        input  RDY, E, D, SETN, ERR
    );

    modport slave (
        input  REQ, ADDR, WDATA, INIT,
        output RDY, E, D, SETN, ERR
    );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// ----------------------------------------------------------------------------
// latch_bank_wr_ctrl
//   Write sequencer for a bank of DEPTH x WIDTH data latches with active-low
//   set pins. Each accepted write goes through a fixed sequence.
//     SETUP : D is driven with the new data.
//     OPEN  : E[addr] is high for PULSE_CYC cycles.
//     HOLD  : E is low again and D is kept stable.
//   This gives one cycle of data setup before the enable window and one cycle
//   of hold after it. An optional bank preset drives all SETN pins low for
//   PULSE_CYC cycles.
//
//   Configuration macro: LATCH_BANK_PRESET_EN
//     defined   : INIT is honoured and the PRESET state exists.
//     undefined : INIT is ignored, SETN is tied to all-1, and the FSM has
//                 four states. Write timing is identical in both builds.
//
//   Ports:
//     CLK       rising-edge clock
//     RN        asynchronous active-low reset
//     bus       latch_bank_wr_ctrl_if.slave (REQ/ADDR/WDATA/INIT in,
//               RDY/E/D/SETN/ERR out); every output comes from a flop
//     dbg_state current FSM state, for observation only
// ----------------------------------------------------------------------------
module latch_bank_wr_ctrl #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int PULSE_CYC = 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    latch_bank_wr_ctrl_if.slave  bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        OPEN   = 3'd2,
`ifdef LATCH_BANK_PRESET_EN
        HOLD   = 3'd3,
        PRESET = 3'd4
`else
        HOLD   = 3'd3
`endif
    } state_t;

    // The counter is loaded with PULSE_CYC-1 and the pulse ends when it is 0.
    // This gives exactly PULSE_CYC cycles of E or SETN.
    localparam logic [3:0]      CNT_LOAD = 4'(PULSE_CYC - 1);
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_ok;
    logic              rdy_q;
    logic [DEPTH-1:0]  e_q;
    logic [WIDTH-1:0]  d_q;
    logic              err_q;

    logic              in_range;
    logic [DEPTH-1:0]  onehot;
    logic              take_init;
    logic              take_req;

    // Compare with one extra bit so that DEPTH == 2**ADDR_W still fits.
    assign in_range = ({1'b0, bus.ADDR} < DEPTH_X);
    // A shift produces no set bit for an out-of-range address. E is also
    // gated explicitly with addr_ok.
    assign onehot   = {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;

    // rdy_q is only ever set while in IDLE, so it doubles as the IDLE qualifier.
    always_comb begin
        take_init = 1'b0;
`ifdef LATCH_BANK_PRESET_EN
        take_init = rdy_q && bus.INIT;
`endif
        take_req  = rdy_q && bus.REQ && !take_init;
    end

`ifdef LATCH_BANK_PRESET_EN
    logic [DEPTH-1:0] setn_q;
`else
    logic init_unused;
    assign init_unused = bus.INIT;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            addr_ok <= 1'b0;
            rdy_q   <= 1'b0;
            e_q     <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
`ifdef LATCH_BANK_PRESET_EN
            setn_q  <= '1;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
`ifdef LATCH_BANK_PRESET_EN
                    if (take_init) begin
                        state  <= PRESET;
                        setn_q <= '0;
                        cnt    <= CNT_LOAD;
                        rdy_q  <= 1'b0;
                    end else
`endif
                    if (take_req) begin
                        state   <= SETUP;
                        addr_q  <= bus.ADDR;
                        addr_ok <= in_range;
                        d_q     <= bus.WDATA;
                        err_q   <= !in_range;
                        rdy_q   <= 1'b0;
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= OPEN;
                    cnt   <= CNT_LOAD;
                    e_q   <= addr_ok ? onehot : '0;
                end
                OPEN: begin
                    if (cnt == 4'd0) begin
                        state <= HOLD;
                        e_q   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
`ifdef LATCH_BANK_PRESET_EN
                PRESET: begin
                    if (cnt == 4'd0) begin
                        state  <= HOLD;
                        setn_q <= '1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RDY   = rdy_q;
    assign bus.E     = e_q;
    assign bus.D     = d_q;
    assign bus.ERR   = err_q;
`ifdef LATCH_BANK_PRESET_EN
    assign bus.SETN  = setn_q;
`else
    assign bus.SETN  = '1;
`endif
    assign dbg_state = state;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
module tb_latch_bank_wr_ctrl;
    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int P      = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rn  = 1'b1;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    latch_bank_wr_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus();

    latch_bank_wr_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PULSE_CYC(P)
    ) dut (
        .CLK(clk),
        .RN(rn),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- latch array model behind the controller ----------------
    logic [WIDTH-1:0] lat [DEPTH];
    int hazards = 0;

    always @(bus.E or bus.D or bus.SETN) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!bus.SETN[i])   lat[i] = '1;
            else if (bus.E[i])  lat[i] = bus.D;
        end
    end

    always @(bus.D) if (rn && bus.E != '0) hazards++;

    always @(negedge clk) begin
        if (rn) begin
            if ($countones(bus.E) > 1) hazards++;
            if (bus.E != '0 && bus.SETN != '1) hazards++;
        end
    end

    // ---------------- scoreboard / reference ----------------
    logic [WIDTH-1:0] ref_mem   [DEPTH];
    bit               ref_valid [DEPTH];
    logic [WIDTH-1:0] exp_q[$];

    function automatic logic [DEPTH-1:0] exp_enable(input int a);
        logic [DEPTH-1:0] r;
        r = '0;
        if (a < DEPTH) r[a] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (bus.RDY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rdy_wait", 32'(bus.RDY), 32'd1);
    endtask

    // Issues one write and checks the full cycle-exact sequence.
    task automatic do_write(input int a, input logic [WIDTH-1:0] w,
                            input logic [DEPTH-1:0] exp_e, input logic exp_err);
        wait_rdy();
        bus.REQ   = 1'b1;
        bus.ADDR  = ADDR_W'(a);
        bus.WDATA = w;
        tick();                      // accept edge
        bus.REQ   = 1'b0;
        bus.ADDR  = ADDR_W'($urandom_range(0, 15));
        bus.WDATA = WIDTH'($urandom);
        check("setup_d",    32'(bus.D),   32'(w));
        check("setup_err",  32'(bus.ERR), 32'(exp_err));
        check("setup_e",    32'(bus.E),   32'd0);
        check("setup_rdy",  32'(bus.RDY), 32'd0);
        check("setup_setn", 32'(bus.SETN), 32'hFF);
        for (int i = 0; i < P; i++) begin
            tick();
            check("open_e",   32'(bus.E),   32'(exp_e));
            check("open_d",   32'(bus.D),   32'(w));
            check("open_err", 32'(bus.ERR), 32'd0);
        end
        tick();
        check("hold_e",   32'(bus.E),   32'd0);
        check("hold_d",   32'(bus.D),   32'(w));
        check("hold_rdy", 32'(bus.RDY), 32'd0);
        tick();
        check("idle_rdy", 32'(bus.RDY), 32'd1);
        check("idle_d",   32'(bus.D),   32'(w));
        if (a < DEPTH) begin
            ref_mem[a]   = w;
            ref_valid[a] = 1'b1;
        end
    endtask

`ifdef LATCH_BANK_PRESET_EN
    task automatic do_preset();
        wait_rdy();
        bus.INIT = 1'b1;
        tick();
        bus.INIT = 1'b0;
        for (int i = 0; i < P; i++) begin
            check("preset_setn", 32'(bus.SETN), 32'h00);
            check("preset_e",    32'(bus.E),    32'd0);
            check("preset_rdy",  32'(bus.RDY),  32'd0);
            tick();
        end
        check("preset_done_setn", 32'(bus.SETN), 32'hFF);
        check("preset_hold_rdy",  32'(bus.RDY),  32'd0);
        tick();
        check("preset_idle_rdy",  32'(bus.RDY),  32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '1;
            ref_valid[i] = 1'b1;
        end
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        int               addr;
        logic [WIDTH-1:0] wdata;
        logic [DEPTH-1:0] exp_e;
        logic             exp_err;
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin : main
        int acc_cyc[$];
        int e_cnt[DEPTH];
        logic [DEPTH-1:0] e_seq[$];
        logic [DEPTH-1:0] last_e;
        int idx;
        logic will_acc;

        vecs[0] = '{3, 8'hA5, 8'h08, 1'b0};
        vecs[1] = '{0, 8'h3C, 8'h01, 1'b0};
        vecs[2] = '{7, 8'hFF, 8'h80, 1'b0};
        vecs[3] = '{9, 8'h11, 8'h00, 1'b1};
        vecs[4] = '{8, 8'h5A, 8'h00, 1'b1};
        vecs[5] = '{15, 8'hC3, 8'h00, 1'b1};
        vecs[6] = '{5, 8'h00, 8'h20, 1'b0};

        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        bus.REQ = 1'b0; bus.INIT = 1'b0; bus.ADDR = '0; bus.WDATA = '0;

        // Reset: asserted between edges, values checked before any edge.
        #2 rn = 1'b0;
        #1;
        check("rst_rdy",  32'(bus.RDY),  32'd0);
        check("rst_e",    32'(bus.E),    32'd0);
        check("rst_d",    32'(bus.D),    32'd0);
        check("rst_setn", 32'(bus.SETN), 32'hFF);
        check("rst_err",  32'(bus.ERR),  32'd0);
        tick();
        tick();
        check("rst_held_rdy", 32'(bus.RDY), 32'd0);
        rn = 1'b1;
        tick();
        check("rst_release_rdy", 32'(bus.RDY), 32'd1);

        // Table-driven writes.
        for (int v = 0; v < 7; v++)
            do_write(vecs[v].addr, vecs[v].wdata, vecs[v].exp_e, vecs[v].exp_err);

        // Back-to-back writes with REQ held high.
        wait_rdy();
        idx = 0;
        for (int i = 0; i < DEPTH; i++) e_cnt[i] = 0;
        last_e    = '0;
        bus.REQ   = 1'b1;
        bus.ADDR  = '0;
        bus.WDATA = 8'h10;
        for (int c = 0; c < 25; c++) begin
            will_acc = bus.RDY && bus.REQ;
            tick();
            if (will_acc) begin
                acc_cyc.push_back(c);
                ref_mem[idx]   = bus.D;
                ref_valid[idx] = 1'b1;
                idx++;
                if (idx < 3) begin
                    bus.ADDR  = ADDR_W'(idx);
                    bus.WDATA = WIDTH'(8'h10 + idx);
                end else begin
                    bus.REQ = 1'b0;
                end
            end
            for (int b = 0; b < DEPTH; b++) if (bus.E[b]) e_cnt[b]++;
            if (bus.E != '0 && bus.E != last_e) e_seq.push_back(bus.E);
            last_e = bus.E;
        end
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(3 + P));
            check("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(3 + P));
        end
        for (int b = 0; b < 3; b++) check("b2b_e_len", 32'(e_cnt[b]), 32'(P));
        check("b2b_e_seq_len", 32'(e_seq.size()), 32'd3);
        if (e_seq.size() == 3) begin
            check("b2b_e_seq0", 32'(e_seq[0]), 32'h01);
            check("b2b_e_seq1", 32'(e_seq[1]), 32'h02);
            check("b2b_e_seq2", 32'(e_seq[2]), 32'h04);
        end

        // INIT and REQ together.
        wait_rdy();
        bus.INIT  = 1'b1;
        bus.REQ   = 1'b1;
        bus.ADDR  = 4'd5;
        bus.WDATA = 8'h5A;
        tick();
        bus.INIT  = 1'b0;
`ifdef LATCH_BANK_PRESET_EN
        for (int i = 0; i < P; i++) begin
            check("ini_setn", 32'(bus.SETN), 32'h00);
            check("ini_e",    32'(bus.E),    32'd0);
            check("ini_rdy",  32'(bus.RDY),  32'd0);
            tick();
        end
        check("ini_setn_end", 32'(bus.SETN), 32'hFF);
        tick();
        check("ini_rdy_back", 32'(bus.RDY), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '1;
            ref_valid[i] = 1'b1;
        end
        tick();                      // pending REQ accepted here
`endif
        bus.REQ = 1'b0;
        check("ini_req_d",    32'(bus.D),    32'h5A);
        check("ini_req_setn", 32'(bus.SETN), 32'hFF);
        check("ini_req_rdy",  32'(bus.RDY),  32'd0);
        tick();
        check("ini_req_e", 32'(bus.E), 32'h20);
        ref_mem[5]   = 8'h5A;
        ref_valid[5] = 1'b1;
        wait_rdy();

        // Reset pulse during OPEN.
        bus.REQ   = 1'b1;
        bus.ADDR  = 4'd4;
        bus.WDATA = 8'h77;
        tick();
        bus.REQ   = 1'b0;
        tick();
        check("rmid_e_open", 32'(bus.E), 32'h10);
        #3 rn = 1'b0;
        #1;
        check("rmid_e",    32'(bus.E),    32'd0);
        check("rmid_d",    32'(bus.D),    32'd0);
        check("rmid_err",  32'(bus.ERR),  32'd0);
        check("rmid_setn", 32'(bus.SETN), 32'hFF);
        check("rmid_rdy",  32'(bus.RDY),  32'd0);
        #2 rn = 1'b1;
        ref_valid[4] = 1'b0;
        tick();
        check("rmid_release_rdy", 32'(bus.RDY), 32'd1);
        do_write(4, 8'h4B, 8'h10, 1'b0);

        // Random writes against the reference scoreboard.
        for (int n = 0; n < 200; n++) begin
            int a;
            logic [WIDTH-1:0] w;
`ifdef LATCH_BANK_PRESET_EN
            if ($urandom_range(0, 19) == 0) do_preset();
`endif
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, DEPTH - 1));
            w = WIDTH'($urandom);
            do_write(a, w, exp_enable(a), (a >= DEPTH));
        end

        // Final array compare through the expected queue.
        for (int i = 0; i < DEPTH; i++) if (ref_valid[i]) exp_q.push_back(ref_mem[i]);
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_valid[i]) begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("latch_entry", 32'(lat[i]), 32'(e));
            end
        end
        check("e_d_hazards", 32'(hazards), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_checks++;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
